// File: rtl/hamming_pkg.sv
// Shared Hamming(21,16) definitions for the encode and decode stages.
package hamming_pkg;

    localparam int unsigned HAM_DATA_W = 16;
    localparam int unsigned HAM_CODE_W = 21;
    localparam int unsigned HAM_PAR_W  = 5;

    typedef logic [HAM_CODE_W-1:0] ham_code_t;

    // FIFO entry: codeword plus a flag recording an injected flip.
    typedef struct packed {
        logic      injected;
        ham_code_t code;
    } ham_entry_t;

    // Positions (bit p-1 for position p) whose index has bit k set, parity position included.
    localparam ham_code_t HAM_MASK_P1  = 21'h155555;
    localparam ham_code_t HAM_MASK_P2  = 21'h066666;
    localparam ham_code_t HAM_MASK_P4  = 21'h187878;
    localparam ham_code_t HAM_MASK_P8  = 21'h007F80;
    localparam ham_code_t HAM_MASK_P16 = 21'h1F8000;

    // Scatter data into non-power-of-two positions, then set each parity bit for even parity.
    function automatic ham_code_t ham_encode(input logic [HAM_DATA_W-1:0] data);
        ham_code_t code;
        code = {data[15:11], 1'b0, data[10:4], 1'b0, data[3:1], 1'b0, data[0], 2'b00};
        code[0]  = ^(code & HAM_MASK_P1);
        code[1]  = ^(code & HAM_MASK_P2);
        code[3]  = ^(code & HAM_MASK_P4);
        code[7]  = ^(code & HAM_MASK_P8);
        code[15] = ^(code & HAM_MASK_P16);
        return code;
    endfunction

    // Syndrome is the position of a single flipped bit, or zero for a clean codeword.
    function automatic logic [HAM_PAR_W-1:0] ham_syndrome(input ham_code_t code);
        return {^(code & HAM_MASK_P16), ^(code & HAM_MASK_P8), ^(code & HAM_MASK_P4),
                ^(code & HAM_MASK_P2), ^(code & HAM_MASK_P1)};
    endfunction

endpackage

// File: rtl/hamming_encode_stream_if.sv
// Upstream word / injection inputs and downstream codeword outputs of the encoder.
interface hamming_encode_stream_if;
    import hamming_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [HAM_DATA_W-1:0] in_data;
    logic                  inj_en;
    logic [4:0]            inj_pos;
    logic                  out_valid;
    logic                  out_ready;
    ham_code_t             out_data;
    logic                  out_injected;
    logic [15:0]           word_count;

    modport master (
        output in_valid, in_data, inj_en, inj_pos, out_ready,
        input  in_ready, out_valid, out_data, out_injected, word_count
    );

    modport slave (
        input  in_valid, in_data, inj_en, inj_pos, out_ready,
        output in_ready, out_valid, out_data, out_injected, word_count
    );

endinterface

// File: rtl/ham_fifo.sv
// Synchronous valid/ready FIFO with a registered occupancy count; no write-to-read bypass.
module ham_fifo #(
    parameter int unsigned width = 22,
    parameter int unsigned depth = 2
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [width-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [width-1:0] rd_data
);

    localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CntW = $clog2(depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(depth);

    logic [width-1:0] mem_q [depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push;
    logic             pop;

    // Ready/valid come only from the registered count, so out_ready never reaches in_ready.
    always_comb begin
        wr_ready = (count_q < DepthCnt);
        rd_valid = (count_q != '0);
        push     = wr_valid && wr_ready;
        pop      = rd_valid && rd_ready;
        rd_data  = mem_q[rd_ptr_q];
    end

    // Entry storage; cleared on reset so an empty FIFO presents zeros.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int unsigned i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap modulo depth (depth need not be a power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hamming_encode_stream.sv
// Streaming Hamming(21,16) encoder with optional single-bit error injection and output FIFO.
module hamming_encode_stream
    import hamming_pkg::*;
#(
    parameter int unsigned data_width     = 16,
    parameter int unsigned encoding_width = 21,
    parameter int unsigned depth          = 2
) (
    input logic                    clk,
    input logic                    rstb,
    hamming_encode_stream_if.slave bus
);

    if (data_width != HAM_DATA_W || encoding_width != HAM_CODE_W) begin : g_bad_width
        $error("hamming_encode_stream: only data_width=16 / encoding_width=21 is supported");
    end
    if (depth < 2 || depth > 4) begin : g_bad_depth
        $error("hamming_encode_stream: depth must be in 2..4");
    end

    ham_code_t   inj_mask;
    logic        inj_hit;
    ham_entry_t  wr_entry;
    ham_entry_t  head;
    logic        fifo_wr_ready;
    logic        fifo_rd_valid;
    logic        push;
    logic [15:0] word_count_q;

    // Encode and optionally flip one position before the word enters the FIFO.
    always_comb begin
        inj_hit           = bus.inj_en && (bus.inj_pos >= 5'd1) && (bus.inj_pos <= 5'd21);
        inj_mask          = inj_hit ? (ham_code_t'(1) << (bus.inj_pos - 5'd1)) : '0;
        wr_entry.code     = ham_encode(bus.in_data) ^ inj_mask;
        wr_entry.injected = inj_hit;
        push              = bus.in_valid && fifo_wr_ready;
    end

    ham_fifo #(
        .width ($bits(ham_entry_t)),
        .depth (depth)
    ) u_fifo (
        .clk      (clk),
        .rstb     (rstb),
        .wr_valid (bus.in_valid),
        .wr_ready (fifo_wr_ready),
        .wr_data  (wr_entry),
        .rd_valid (fifo_rd_valid),
        .rd_ready (bus.out_ready),
        .rd_data  (head)
    );

    // Count of accepted words, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            word_count_q <= '0;
        end else if (push) begin
            word_count_q <= word_count_q + 16'd1;
        end
    end

    // Outputs come straight from registered FIFO/counter state.
    always_comb begin
        bus.in_ready     = fifo_wr_ready;
        bus.out_valid    = fifo_rd_valid;
        bus.out_data     = head.code;
        bus.out_injected = head.injected;
        bus.word_count   = word_count_q;
    end

endmodule

// File: tb/tb_hamming_encode_stream.sv
// Directed + random bench for hamming_encode_stream with a queue scoreboard.
module tb_hamming_encode_stream;

    typedef struct {
        logic [20:0] code;
        logic        inj;
    } exp_t;

    logic clk;
    logic rstb;
    int   vectors;
    int   miscompares;
    int   rx_count;
    exp_t sb[$];

    hamming_encode_stream_if bus ();

    hamming_encode_stream #(
        .data_width     (16),
        .encoding_width (21),
        .depth          (2)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder written position by position.
    function automatic logic [20:0] model_enc(input logic [15:0] d);
        logic [20:0] c;
        logic        par;
        int          j;
        c = '0;
        j = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 21; p++) begin
                if (((p >> k) & 1) == 1) par = par ^ c[p-1];
            end
            c[(1 << k) - 1] = par;
        end
        return c;
    endfunction

    function automatic exp_t model(input logic [15:0] d, input logic en, input logic [4:0] pos);
        exp_t e;
        e.code = model_enc(d);
        e.inj  = en && (pos >= 5'd1) && (pos <= 5'd21);
        if (e.inj) e.code[pos-1] = ~e.code[pos-1];
        return e;
    endfunction

    function automatic int model_syn(input logic [20:0] c);
        int s;
        s = 0;
        for (int p = 1; p <= 21; p++) begin
            if (c[p-1]) s = s ^ p;
        end
        return s;
    endfunction

    function automatic logic [15:0] model_extract(input logic [20:0] c);
        logic [15:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = c[p-1];
                j++;
            end
        end
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [15:0] d, input logic en,
                            input logic [4:0] pos, input logic [20:0] exp_code,
                            input logic exp_inj);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.inj_en   = en;
        bus.inj_pos  = pos;
        step();
        bus.in_valid = 1'b0;
        bus.inj_en   = 1'b0;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp_code));
        check({tag, "_inj"}, 32'(bus.out_injected), 32'(exp_inj));
        step();
    endtask

    // Scoreboard: pop on each accepted output, push the model result on each accepted input.
    always @(negedge clk) begin
        if (rstb) begin
            if (bus.out_valid && bus.out_ready) begin
                vectors++;
                assert (sb.size() != 0) else begin
                    miscompares++;
                    $error("FAIL sb_underflow: observed codeword 0x%0h required none", bus.out_data);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_code", 32'(bus.out_data), 32'(e.code));
                    check("sb_inj", 32'(bus.out_injected), 32'(e.inj));
                    rx_count++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.in_data, bus.inj_en, bus.inj_pos));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          sent;
        int          cyc;
        int          rx_base;
        int          syn;
        logic        fire;
        logic [15:0] d;
        logic [20:0] fixed;

        vectors      = 0;
        miscompares  = 0;
        rx_count     = 0;
        rstb         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.inj_en   = 1'b0;
        bus.inj_pos  = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_inj", 32'(bus.out_injected), 32'd0);
        check("rst_word_count", 32'(bus.word_count), 32'd0);
        rstb = 1'b1;
        step();

        // Directed encodes and injections.
        send_one("enc_0000", 16'h0000, 1'b0, 5'd0, 21'h000000, 1'b0);
        send_one("enc_0001", 16'h0001, 1'b0, 5'd0, 21'h000007, 1'b0);
        send_one("enc_ffff", 16'hFFFF, 1'b0, 5'd0, 21'h1FFFFE, 1'b0);
        send_one("inj_pos5", 16'h0000, 1'b1, 5'd5, 21'h000010, 1'b1);
        send_one("inj_pos0", 16'h0000, 1'b1, 5'd0, 21'h000000, 1'b0);
        send_one("inj_pos22", 16'h0000, 1'b1, 5'd22, 21'h000000, 1'b0);
        check("empty_after_directed", 32'(bus.out_valid), 32'd0);

        // Backpressure: two accepted, third held until a slot frees.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0001;
        step();
        check("bp_ready_after1", 32'(bus.in_ready), 32'd1);
        bus.in_data = 16'hFFFF;
        step();
        check("bp_full", 32'(bus.in_ready), 32'd0);
        bus.in_data = 16'h1234;
        step();
        check("bp_still_full", 32'(bus.in_ready), 32'd0);
        check("bp_head_stable", 32'(bus.out_data), 32'h000007);
        check("bp_valid_stable", 32'(bus.out_valid), 32'd1);
        check("bp_count_8", 32'(bus.word_count), 32'd8);
        bus.out_ready = 1'b1;
        step();
        check("bp_second", 32'(bus.out_data), 32'h1FFFFE);
        check("bp_slot_free", 32'(bus.in_ready), 32'd1);
        check("bp_count_still_8", 32'(bus.word_count), 32'd8);
        step();
        bus.in_valid = 1'b0;
        check("bp_third", 32'(bus.out_data), 32'(model_enc(16'h1234)));
        check("bp_count_9", 32'(bus.word_count), 32'd9);
        step();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Reset with two entries buffered.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h5555;
        step();
        bus.in_data = 16'hAAAA;
        step();
        bus.in_valid = 1'b0;
        check("mid_full", 32'(bus.in_ready), 32'd0);
        rstb = 1'b0;
        step();
        rstb = 1'b1;
        sb.delete();
        check("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_word_count", 32'(bus.word_count), 32'd0);
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("mid_no_stale", 32'(bus.out_valid), 32'd0);

        // Random streaming of 100 words.
        rx_base = rx_count;
        sent    = 0;
        cyc     = 0;
        while (sent < 100 && cyc < 3000) begin
            if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 16'($urandom);
                bus.inj_en   = ($urandom_range(0, 3) == 0);
                bus.inj_pos  = 5'($urandom_range(0, 23));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            fire = bus.in_valid && bus.in_ready;
            step();
            cyc++;
            if (fire) begin
                sent++;
                bus.in_valid = 1'b0;
                bus.inj_en   = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream_sent", 32'(sent), 32'd100);
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        step();
        check("stream_drain", 32'(sb.size()), 32'd0);
        check("stream_rx", 32'(rx_count - rx_base), 32'd100);
        check("stream_word_count", 32'(bus.word_count), 32'd100);

        // Loopback through a reference decoder, one flipped position per word.
        for (int p = 1; p <= 21; p++) begin
            d = 16'($urandom);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.inj_en   = 1'b1;
            bus.inj_pos  = 5'(p);
            step();
            bus.in_valid = 1'b0;
            bus.inj_en   = 1'b0;
            check("lb_inj", 32'(bus.out_injected), 32'd1);
            syn = model_syn(bus.out_data);
            check("lb_syndrome", 32'(syn), 32'(p));
            fixed = bus.out_data;
            if (syn >= 1 && syn <= 21) fixed[syn-1] = ~fixed[syn-1];
            check("lb_data", 32'(model_extract(fixed)), 32'(d));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
